dma32_mem_responder: RTL and testbench

//   Target side of the 32-bit accelerator DMA interface: accepts read/write ctrl requests from an

---
 rtl/dma32_resp_pkg.sv | 6 +
 rtl/dma32_mem_responder_if.sv | 35 +++
 rtl/dma32_resp_mem.sv | 22 ++
 rtl/dma32_mem_responder.sv | 85 ++++++++
 tb/tb_dma32_mem_responder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dma32_resp_pkg.sv
// dma32_resp_pkg: shared FSM/grant types and the DMA word-size encoding
package dma32_resp_pkg;
    localparam logic [2:0] DMA_SIZE_WORD = 3'b010;
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;
    typedef enum logic {GNT_READ, GNT_WRITE} grant_t;
endpackage

// File: rtl/dma32_mem_responder_if.sv
// dma32_mem_responder_if: accelerator DMA ctrl/channel bundle between accelerator (master) and memory (slave)
interface dma32_mem_responder_if;
    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_chnl_valid;
    logic        dma_read_chnl_ready;
    logic [31:0] dma_read_chnl_data;
    logic        dma_write_ctrl_valid;
    logic        dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index;
    logic [31:0] dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic        dma_write_chnl_valid;
    logic        dma_write_chnl_ready;
    logic [31:0] dma_write_chnl_data;
    modport master (
        output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_chnl_ready,
               dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
        input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
               dma_write_ctrl_ready, dma_write_chnl_ready
    );
    modport slave (
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_chnl_ready,
               dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
        output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
               dma_write_ctrl_ready, dma_write_chnl_ready
    );
endinterface

// File: rtl/dma32_resp_mem.sv
// dma32_resp_mem: word array with one synchronous write port and two asynchronous read ports
module dma32_resp_mem
    import dma32_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [31:0]       rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [31:0]       rdata_b
);
    logic [31:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/dma32_mem_responder.sv
// dma32_mem_responder: DMA target that serves accelerator read/write bursts from an on-chip word array
module dma32_mem_responder
    import dma32_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    dma32_mem_responder_if.slave  dma,
    input  logic                  bd_we,
    input  logic [ADDR_W-1:0]     bd_addr,
    input  logic [31:0]           bd_wdata,
    output logic [31:0]           bd_rdata,
    output logic                  busy,
    output logic                  err
);
    state_t            state, state_nx;
    grant_t            last_grant, grant;
    logic [ADDR_W-1:0] addr, fetch_addr, mem_waddr;
    logic [31:0]       remaining, rd_data, fetch_data, bd_data, mem_wdata;
    logic              idle, rd_acc, wr_acc, rd_hs, wr_hs, last, mem_we;
    logic              unused_idx_bits;
    assign unused_idx_bits = ^{dma.dma_read_ctrl_data_index[31:ADDR_W], dma.dma_write_ctrl_data_index[31:ADDR_W]};
    always_comb begin
        idle  = state == IDLE;
        grant = (dma.dma_read_ctrl_valid && dma.dma_write_ctrl_valid)
              ? (last_grant == GNT_READ ? GNT_WRITE : GNT_READ)
              : (dma.dma_read_ctrl_valid ? GNT_READ : GNT_WRITE);
        dma.dma_read_ctrl_ready  = idle && dma.dma_read_ctrl_valid && grant == GNT_READ;
        dma.dma_write_ctrl_ready = idle && dma.dma_write_ctrl_valid && grant == GNT_WRITE;
        dma.dma_read_chnl_valid  = state == RD_BURST;
        dma.dma_read_chnl_data   = state == RD_BURST ? rd_data : '0;
        dma.dma_write_chnl_ready = state == WR_BURST;
        rd_acc = dma.dma_read_ctrl_valid && dma.dma_read_ctrl_ready;
        wr_acc = dma.dma_write_ctrl_valid && dma.dma_write_ctrl_ready;
        rd_hs  = dma.dma_read_chnl_valid && dma.dma_read_chnl_ready;
        wr_hs  = dma.dma_write_chnl_valid && dma.dma_write_chnl_ready;
        last   = remaining == 32'd1;
        // first beat is fetched at accept, later beats one address ahead of the handshake
        fetch_addr = idle ? dma.dma_read_ctrl_data_index[ADDR_W-1:0] : addr + ADDR_W'(1);
        mem_we    = wr_hs || (idle && bd_we);
        mem_waddr = wr_hs ? addr : bd_addr;
        mem_wdata = wr_hs ? dma.dma_write_chnl_data : bd_wdata;
        busy      = !idle;
        state_nx  = (rd_acc && dma.dma_read_ctrl_data_length != '0) ? RD_BURST
                  : (wr_acc && dma.dma_write_ctrl_data_length != '0) ? WR_BURST
                  : ((rd_hs || wr_hs) && last) ? IDLE
                  : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_WRITE;
            addr       <= '0;
            remaining  <= '0;
            rd_data    <= '0;
            err        <= 1'b0;
            bd_rdata   <= '0;
        end else begin
            state    <= state_nx;
            bd_rdata <= bd_data;
            if (rd_acc || wr_acc) begin
                last_grant <= rd_acc ? GNT_READ : GNT_WRITE;
                addr       <= rd_acc ? dma.dma_read_ctrl_data_index[ADDR_W-1:0] : dma.dma_write_ctrl_data_index[ADDR_W-1:0];
                remaining  <= rd_acc ? dma.dma_read_ctrl_data_length : dma.dma_write_ctrl_data_length;
                err        <= err | ((rd_acc ? dma.dma_read_ctrl_data_size : dma.dma_write_ctrl_data_size) != DMA_SIZE_WORD);
            end
            if (rd_acc || rd_hs) rd_data <= fetch_data;
            if (rd_hs || wr_hs) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - 32'd1;
            end
        end
    end
    dma32_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (fetch_addr),
        .rdata_a (fetch_data),
        .raddr_b (bd_addr),
        .rdata_b (bd_data)
    );
endmodule

// File: tb/tb_dma32_mem_responder.sv
// tb_dma32_mem_responder: directed vector table plus hand sequences for arbitration, len-0 and reset abort
module tb_dma32_mem_responder;
    localparam int ADDR_W = 10;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [31:0]       bd_wdata = '0;
    logic [31:0]       bd_rdata;
    logic              busy, err;
    int                passed = 0;
    int                total = 0;
    dma32_mem_responder_if dma();
    dma32_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .dma      (dma),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata),
        .busy     (busy),
        .err      (err)
    );
    always #5 clk = ~clk;
    typedef struct {
        bit                wr;
        logic [31:0]       idx;
        int                len;
        logic [2:0]        size;
        bit                stall;
        logic [3:0][31:0]  d;
        bit                exp_err;
    } vec_t;
    vec_t vecs[8];
    function automatic vec_t mk(bit wr, logic [31:0] idx, int len, logic [2:0] size, bit stall,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] d3, bit e);
        vec_t v;
        v.wr = wr; v.idx = idx; v.len = len; v.size = size; v.stall = stall;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.exp_err = e;
        return v;
    endfunction
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic bd_write(logic [ADDR_W-1:0] a, logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        step();
        bd_we = 1'b0;
    endtask
    task automatic bd_check(string name, logic [ADDR_W-1:0] a, logic [31:0] exp);
        bd_addr = a;
        step();
        check(name, bd_rdata, exp);
    endtask
    task automatic issue(bit wr, logic [31:0] idx, int len, logic [2:0] size);
        bit ok = 1'b0;
        if (wr) begin
            dma.dma_write_ctrl_valid = 1'b1; dma.dma_write_ctrl_data_index = idx;
            dma.dma_write_ctrl_data_length = len; dma.dma_write_ctrl_data_size = size;
        end else begin
            dma.dma_read_ctrl_valid = 1'b1; dma.dma_read_ctrl_data_index = idx;
            dma.dma_read_ctrl_data_length = len; dma.dma_read_ctrl_data_size = size;
        end
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = wr ? dma.dma_write_ctrl_ready : dma.dma_read_ctrl_ready;
            step();
        end
        dma.dma_write_ctrl_valid = 1'b0;
        dma.dma_read_ctrl_valid = 1'b0;
        check("ctrl_accept", 32'(ok), 32'd1);
    endtask
    task automatic run_read(int len, logic [3:0][31:0] d, bit stall);
        int n = 0;
        int cyc = 0;
        bit r;
        while (n < len && cyc < 40) begin
            r = !stall || (cyc % 2 == 0);
            dma.dma_read_chnl_ready = r;
            @(negedge clk);
            check("rd_valid", 32'(dma.dma_read_chnl_valid), 32'd1);
            check(r ? "rd_data" : "rd_stall_data", dma.dma_read_chnl_data, d[n]);
            if (r) n++;
            step();
            cyc++;
        end
        dma.dma_read_chnl_ready = 1'b0;
        check("rd_beats", n, len);
        if (!stall) check("rd_cycles", cyc, len);
        @(negedge clk);
        check("rd_valid_end", 32'(dma.dma_read_chnl_valid), 32'd0);
        check("rd_busy_end", 32'(busy), 32'd0);
        step();
    endtask
    task automatic run_write(int len, logic [3:0][31:0] d);
        int i = 0;
        int cyc = 0;
        bit h;
        while (i < len && cyc < 40) begin
            dma.dma_write_chnl_valid = 1'b1;
            dma.dma_write_chnl_data = d[i];
            @(negedge clk);
            h = dma.dma_write_chnl_ready;
            step();
            if (h) i++;
            cyc++;
        end
        dma.dma_write_chnl_valid = 1'b0;
        check("wr_beats", i, len);
        check("wr_cycles", cyc, len);
        @(negedge clk);
        check("wr_ready_end", 32'(dma.dma_write_chnl_ready), 32'd0);
        check("wr_busy_end", 32'(busy), 32'd0);
        step();
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int act;
        dma.dma_read_ctrl_valid = 1'b0; dma.dma_read_ctrl_data_index = '0;
        dma.dma_read_ctrl_data_length = '0; dma.dma_read_ctrl_data_size = 3'b010;
        dma.dma_read_chnl_ready = 1'b0;
        dma.dma_write_ctrl_valid = 1'b0; dma.dma_write_ctrl_data_index = '0;
        dma.dma_write_ctrl_data_length = '0; dma.dma_write_ctrl_data_size = 3'b010;
        dma.dma_write_chnl_valid = 1'b0; dma.dma_write_chnl_data = '0;
        vecs[0] = mk(0, 32'd0,     4, 3'b010, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
        vecs[1] = mk(1, 32'd8,     3, 3'b010, 0, 32'h11, 32'h22, 32'h33, 32'h0,  0);
        vecs[2] = mk(0, 32'd8,     3, 3'b010, 1, 32'h11, 32'h22, 32'h33, 32'h0,  0);
        vecs[3] = mk(0, 32'd1023,  2, 3'b010, 0, 32'hFF, 32'hA0, 32'h0,  32'h0,  0);
        vecs[4] = mk(1, 32'h7FF,   2, 3'b010, 0, 32'h55, 32'h66, 32'h0,  32'h0,  0);
        vecs[5] = mk(0, 32'h3FF,   2, 3'b010, 0, 32'h55, 32'h66, 32'h0,  32'h0,  0);
        vecs[6] = mk(0, 32'd8,     1, 3'b011, 0, 32'h11, 32'h0,  32'h0,  32'h0,  1);
        vecs[7] = mk(0, 32'd9,     1, 3'b010, 0, 32'h22, 32'h0,  32'h0,  32'h0,  1);
        repeat (3) step();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_valid", 32'(dma.dma_read_chnl_valid), 32'd0);
        check("rst_wr_ready", 32'(dma.dma_write_chnl_ready), 32'd0);
        check("rst_bd_rdata", bd_rdata, 32'd0);
        step();
        rst = 1'b0;
        bd_write(10'd0, 32'hA0);
        bd_write(10'd1, 32'hA1);
        bd_write(10'd2, 32'hA2);
        bd_write(10'd3, 32'hA3);
        bd_write(10'd1023, 32'hFF);
        bd_write(10'd34, 32'hDEAD);
        bd_check("bd_rdata", 10'd2, 32'hA2);
        // simultaneous requests: first READ, then WRITE
        dma.dma_read_ctrl_valid = 1'b1; dma.dma_read_ctrl_data_index = 32'd0; dma.dma_read_ctrl_data_length = 32'd1;
        dma.dma_write_ctrl_valid = 1'b1; dma.dma_write_ctrl_data_index = 32'd16; dma.dma_write_ctrl_data_length = 32'd1;
        @(negedge clk);
        check("gnt1_rd_ready", 32'(dma.dma_read_ctrl_ready), 32'd1);
        check("gnt1_wr_ready", 32'(dma.dma_write_ctrl_ready), 32'd0);
        step();
        dma.dma_read_ctrl_valid = 1'b0; dma.dma_write_ctrl_valid = 1'b0;
        dma.dma_read_chnl_ready = 1'b1;
        @(negedge clk);
        check("gnt1_rd_valid", 32'(dma.dma_read_chnl_valid), 32'd1);
        check("gnt1_rd_data", dma.dma_read_chnl_data, 32'hA0);
        step();
        dma.dma_read_chnl_ready = 1'b0;
        dma.dma_read_ctrl_valid = 1'b1; dma.dma_write_ctrl_valid = 1'b1;
        @(negedge clk);
        check("gnt2_rd_ready", 32'(dma.dma_read_ctrl_ready), 32'd0);
        check("gnt2_wr_ready", 32'(dma.dma_write_ctrl_ready), 32'd1);
        step();
        dma.dma_read_ctrl_valid = 1'b0; dma.dma_write_ctrl_valid = 1'b0;
        dma.dma_write_chnl_valid = 1'b1; dma.dma_write_chnl_data = 32'h77;
        @(negedge clk);
        check("gnt2_wr_chnl_ready", 32'(dma.dma_write_chnl_ready), 32'd1);
        step();
        dma.dma_write_chnl_valid = 1'b0;
        bd_check("gnt2_mem16", 10'd16, 32'h77);
        // zero-length request is accepted without any burst activity
        issue(0, 32'd4, 0, 3'b010);
        act = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busy || dma.dma_read_chnl_valid || dma.dma_write_chnl_ready) act++;
            step();
        end
        check("len0_activity", act, 0);
        check("len0_err", 32'(err), 32'd0);
        for (int k = 0; k < 8; k++) begin
            issue(vecs[k].wr, vecs[k].idx, vecs[k].len, vecs[k].size);
            if (vecs[k].wr) run_write(vecs[k].len, vecs[k].d);
            else run_read(vecs[k].len, vecs[k].d, vecs[k].stall);
            check($sformatf("v%0d_err", k), 32'(err), 32'(vecs[k].exp_err));
        end
        // reset in the middle of an 8-beat write, with a backdoor write attempted while busy
        issue(1, 32'd32, 8, 3'b010);
        dma.dma_write_chnl_valid = 1'b1; dma.dma_write_chnl_data = 32'h100;
        bd_we = 1'b1; bd_addr = 10'd34; bd_wdata = 32'hBAD;
        @(negedge clk);
        check("abort_wr_ready", 32'(dma.dma_write_chnl_ready), 32'd1);
        step();
        bd_we = 1'b0;
        dma.dma_write_chnl_data = 32'h101;
        step();
        dma.dma_write_chnl_valid = 1'b0;
        dma.dma_write_chnl_data = 32'h102;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wr_ready0", 32'(dma.dma_write_chnl_ready), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        step();
        bd_check("abort_mem32", 10'd32, 32'h100);
        bd_check("abort_mem33", 10'd33, 32'h101);
        bd_check("abort_mem34", 10'd34, 32'hDEAD);
        bd_check("abort_mem0", 10'd0, 32'h66);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
